count_wrap_monitor: RTL and testbench

//  Downstream consumer of the 8-bit event counter's count/overflow outputs.

---
 rtl/count_mon_pkg.sv | 13 +
 rtl/count_wrap_monitor_sync_fifo.sv | 57 +++++
 rtl/count_wrap_monitor.sv | 65 ++++++
 tb/tb_count_wrap_monitor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
// count_mon_pkg: shared widths, threshold default and record layout for count_wrap_monitor.
package count_mon_pkg;
    localparam int CNT_W_DEF = 8;
    localparam int WRAP_W_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam logic [7:0] THRESH_DEF = 8'hF0;
    typedef struct packed {
        logic flag;
        logic [WRAP_W_DEF-1:0] wrap;
        logic [CNT_W_DEF-1:0] count;
    } rec_t;
    localparam int REC_W = $bits(rec_t);
endpackage

// File: rtl/count_wrap_monitor_sync_fifo.sv
// sync_fifo: synchronous FIFO with registered output stage and sync flush.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0] count, count_n;
    logic wr_en, rd_en, has_next;
    // count covers every entry not yet popped, including the one presented on dout
    assign rd_en = pop & valid;
    assign wr_en = push & (count != (AW+1)'(DEPTH) || rd_en);
    assign count_n = count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    assign rd_nxt = rd_ptr + AW'(rd_en);
    assign has_next = count != (AW+1)'(rd_en);
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            valid  <= 1'b0;
            dout   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            valid  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_nxt;
            count  <= count_n;
            full   <= count_n == (AW+1)'(DEPTH);
            if (!valid || rd_en) begin
                valid <= has_next;
                if (has_next)
                    dout <= mem[rd_nxt];
            end
        end
    end
endmodule

// File: rtl/count_wrap_monitor.sv
// count_wrap_monitor: counts upstream wrap events and streams sampled
// {flag, wrap count, count} records through a small FIFO.
module count_wrap_monitor
    import count_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WRAP_W = WRAP_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [CNT_W-1:0] THRESH = CNT_W'(THRESH_DEF)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [CNT_W-1:0]        count_in,
    input  logic                    overflow_in,
    input  logic                    sample_req,
    input  logic                    clr,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [WRAP_W+CNT_W:0]   rec_data,
    output logic                    fifo_full,
    output logic [7:0]              drop_cnt,
    output logic                    thresh_hit
);
    logic [CNT_W-1:0] s1_count;
    logic s1_ovf, s1_req, s1_thr, ovf_prev;
    logic [WRAP_W-1:0] wrap_cnt, wrap_nxt;
    logic wrap_ev, push, pop, drop;
    assign wrap_ev = s1_ovf & ~ovf_prev;
    assign wrap_nxt = (wrap_ev && wrap_cnt != '1) ? wrap_cnt + WRAP_W'(1) : wrap_cnt;
    assign push = s1_req & ~clr;
    assign pop = rec_valid & rec_ready;
    assign drop = push & fifo_full & ~pop;
    assign thresh_hit = s1_thr;
    // edge-detect history survives clr so a held overflow level is not recounted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_count <= '0;
            s1_ovf   <= 1'b0;
            s1_req   <= 1'b0;
            s1_thr   <= 1'b0;
            ovf_prev <= 1'b0;
            wrap_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            s1_count <= count_in;
            s1_ovf   <= overflow_in;
            s1_req   <= sample_req;
            s1_thr   <= count_in >= THRESH;
            ovf_prev <= s1_ovf;
            wrap_cnt <= clr ? '0 : wrap_nxt;
            drop_cnt <= clr ? 8'd0 : (drop && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
        end
    end
    sync_fifo #(.WIDTH(WRAP_W + CNT_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (clr),
        .push    (push),
        .pop     (pop),
        .din     ({s1_thr, wrap_nxt, s1_count}),
        .dout    (rec_data),
        .valid   (rec_valid),
        .full    (fifo_full)
    );
endmodule

// File: tb/tb_count_wrap_monitor.sv
// tb_count_wrap_monitor: directed and random stimulus on 16-bit and 4-bit
// wrap-counter instances, checked against a record-queue reference model.
module tb_count_wrap_monitor;
    import count_mon_pkg::*;
    logic clk = 1'b0, reset_n = 1'b0;
    logic [7:0] count_in = '0;
    logic overflow_in = 1'b0, sample_req = 1'b0, clr = 1'b0, rec_ready = 1'b0;
    logic rec_valid, fifo_full, thresh_hit, rec_valid4, fifo_full4, thresh_hit4;
    logic [24:0] rec_data;
    logic [12:0] rec_data4;
    logic [7:0] drop_cnt, drop_cnt4;
    typedef struct {bit flag; int wrap; int cnt;} mrec_t;
    mrec_t q[$];
    int wraps, drops, p_cnt;
    bit p_ovf, pp_ovf, p_req, p_thr;
    int errors = 0, checks = 0;
    always #5 clk = ~clk;
    count_wrap_monitor dut (
        .clk(clk), .reset_n(reset_n), .count_in(count_in), .overflow_in(overflow_in),
        .sample_req(sample_req), .clr(clr), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_data(rec_data), .fifo_full(fifo_full), .drop_cnt(drop_cnt), .thresh_hit(thresh_hit)
    );
    count_wrap_monitor #(.WRAP_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .count_in(count_in), .overflow_in(overflow_in),
        .sample_req(sample_req), .clr(clr), .rec_valid(rec_valid4), .rec_ready(rec_ready),
        .rec_data(rec_data4), .fifo_full(fifo_full4), .drop_cnt(drop_cnt4), .thresh_hit(thresh_hit4)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic [24:0] exp16(input mrec_t r);
        rec_t x;
        x.flag = r.flag;
        x.wrap = (r.wrap > 65535) ? 16'hFFFF : 16'(r.wrap);
        x.count = 8'(r.cnt);
        return x;
    endfunction
    function automatic logic [12:0] exp4(input mrec_t r);
        return {r.flag, (r.wrap > 15) ? 4'hF : 4'(r.wrap), 8'(r.cnt)};
    endfunction
    task automatic model_reset();
        q.delete();
        wraps = 0; drops = 0; p_cnt = 0;
        p_ovf = 0; pp_ovf = 0; p_req = 0; p_thr = 0;
    endtask
    // one clock: check handshake data before the edge, update the model at the edge, check after
    task automatic tick();
        bit pop, oi, ri, cl;
        int ci;
        mrec_t r;
        @(negedge clk);
        pop = rec_valid && rec_ready;
        check("valid_match", rec_valid4, rec_valid);
        if (pop) begin
            if (q.size() == 0) check("pop_model_empty", rec_valid, 0);
            else begin
                check("data16", rec_data, exp16(q[0]));
                check("data4", rec_data4, exp4(q[0]));
            end
        end
        ci = count_in; oi = overflow_in; ri = sample_req; cl = clr;
        @(posedge clk);
        if (cl) begin
            wraps = 0; drops = 0; q.delete();
        end else begin
            if (p_ovf && !pp_ovf) wraps++;
            if (pop && q.size() > 0) void'(q.pop_front());
            if (p_req) begin
                r.flag = p_thr; r.wrap = wraps; r.cnt = p_cnt;
                if (q.size() < 4) q.push_back(r);
                else drops++;
            end
        end
        pp_ovf = p_ovf; p_ovf = oi; p_req = ri; p_cnt = ci; p_thr = ci >= 8'hF0;
        #1;
        check("full", fifo_full, q.size() == 4);
        check("full4", fifo_full4, q.size() == 4);
        check("drop", drop_cnt, drops > 255 ? 255 : drops);
        check("drop4", drop_cnt4, drops > 255 ? 255 : drops);
        check("thresh", thresh_hit, p_thr);
        check("thresh4", thresh_hit4, p_thr);
        if (q.size() == 0) check("empty_valid", rec_valid, 0);
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_valid"}, rec_valid, 0);
        check({tag, "_data"}, rec_data, 0);
        check({tag, "_full"}, fifo_full, 0);
        check({tag, "_drop"}, drop_cnt, 0);
        check({tag, "_thresh"}, thresh_hit, 0);
        check({tag, "_valid4"}, rec_valid4, 0);
        check({tag, "_data4"}, rec_data4, 0);
    endtask
    initial begin
        model_reset();
        #12;
        check_zero("reset");
        reset_n = 1'b1;
        // two wrap events from a 3-cycle level and a 1-cycle pulse
        overflow_in = 1; repeat (3) tick();
        overflow_in = 0; tick();
        overflow_in = 1; tick();
        overflow_in = 0; repeat (2) tick();
        count_in = 8'h5A; sample_req = 1; tick();
        sample_req = 0; tick();
        check("lat_n1", rec_valid, 0);
        tick();
        check("lat_n2", rec_valid, 1);
        check("rec_5a", rec_data, {1'b0, 16'h0002, 8'h5A});
        rec_ready = 1; tick();
        rec_ready = 0;
        // threshold boundary
        count_in = 8'hF0; sample_req = 1; tick();
        check("thr_f0", thresh_hit, 1);
        count_in = 8'hEF; tick();
        check("thr_ef", thresh_hit, 0);
        sample_req = 0; rec_ready = 1; repeat (6) tick();
        // overfill with consumer stalled
        rec_ready = 0; sample_req = 1;
        for (int i = 0; i < 6; i++) begin count_in = 8'(8'h10 + i); tick(); end
        sample_req = 0; repeat (2) tick();
        check("full_set", fifo_full, 1);
        check("drop_two", drop_cnt, 2);
        rec_ready = 1; tick();
        check("full_falls", fifo_full, 0);
        repeat (5) tick();
        check("drained", rec_valid, 0);
        // async reset with two records buffered
        rec_ready = 0; sample_req = 1; repeat (2) tick();
        sample_req = 0; repeat (3) tick();
        check("two_held", rec_valid, 1);
        #2 reset_n = 0;
        #1 check_zero("midrst");
        @(posedge clk); #2 reset_n = 1;
        model_reset();
        // clr beats a same-cycle sample and wrap event
        sample_req = 1; repeat (6) tick();
        sample_req = 0; overflow_in = 0; tick();
        overflow_in = 1; sample_req = 1; tick();
        sample_req = 0; clr = 1; tick();
        clr = 0; overflow_in = 0; tick();
        check("clr_valid", rec_valid, 0);
        check("clr_full", fifo_full, 0);
        check("clr_drop", drop_cnt, 0);
        count_in = 8'h33; sample_req = 1; tick();
        sample_req = 0; repeat (2) tick();
        check("clr_rec_valid", rec_valid, 1);
        check("clr_wrap", {16'h0, rec_data[23:8]}, 0);
        rec_ready = 1; repeat (3) tick();
        rec_ready = 0;
        // 17 wrap events saturate the 4-bit counter only
        for (int i = 0; i < 17; i++) begin
            overflow_in = 1; tick();
            overflow_in = 0; tick();
        end
        count_in = 8'h01; sample_req = 1; tick();
        sample_req = 0; repeat (2) tick();
        check("sat_valid", rec_valid4, 1);
        check("sat_wrap4", {28'h0, rec_data4[11:8]}, 4'hF);
        check("sat_wrap16", {16'h0, rec_data[23:8]}, 17);
        rec_ready = 1; repeat (3) tick();
        // random traffic
        for (int i = 0; i < 600; i++) begin
            count_in = 8'($urandom);
            overflow_in = ($urandom_range(0, 3) == 0) ? ~overflow_in : overflow_in;
            sample_req = $urandom_range(0, 2) == 0;
            clr = $urandom_range(0, 80) == 0;
            rec_ready = $urandom_range(0, 2) != 0;
            tick();
        end
        sample_req = 0; clr = 0; rec_ready = 1;
        repeat (8) tick();
        check("final_empty", rec_valid, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
